// File: rtl/regr_seq.sv
// regr_seq -- sequencer for a batch of linear regressions.
//
// Each regression step streams N_SAMP samples out of sample memory into the
// XTX/XTY accumulators, captures both accumulator results, hands the XTX sums
// to MAT_INV, waits for the inverse, then moves to the next step. A watchdog
// aborts the job if any wait state stalls for TMO cycles.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   start, n_steps              job request (sampled in IDLE only)
//   busy, step_idx              job status / current step
//   mem_rd, mem_addr            sample-memory read port, addr = {step_idx, k}
//   acc_start                   one-cycle start for XTX and XTY
//   xtx_valid, ans0..ans2       XTX completion + sums
//   xty_valid, xty1, xty2       XTY completion + sums
//   sig0..sig2                  held XTX sums feeding MAT_INV
//   inv_start, inv_valid        MAT_INV handshake
//   by1, by2                    held XTY sums for the current step
//   step_done, job_done         end-of-step / end-of-job pulses
//   err                         sticky watchdog flag
module regr_seq #(
    parameter int N_SAMP = 256,
    parameter int TMO    = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  n_steps,
    output logic        busy,
    output logic [7:0]  step_idx,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    output logic        acc_start,
    input  logic        xtx_valid,
    input  logic        xty_valid,
    input  logic [8:0]  ans0,
    input  logic [20:0] ans1,
    input  logic [32:0] ans2,
    input  logic [32:0] xty1,
    input  logic [32:0] xty2,
    output logic [8:0]  sig0,
    output logic [20:0] sig1,
    output logic [32:0] sig2,
    output logic        inv_start,
    input  logic        inv_valid,
    output logic [32:0] by1,
    output logic [32:0] by2,
    output logic        step_done,
    output logic        job_done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE, FEED, WAIT_ACC, INV, WAIT_INV, STEP_END
    } state_t;

    localparam int         WDW    = $clog2(TMO + 1);
    localparam logic [7:0] K_LAST = 8'(N_SAMP - 1);

    state_t           state, nxt;
    logic [WDW-1:0]   wd;
    logic [7:0]       k;
    logic [7:0]       last_idx;
    logic             got_x, got_y;
    logic             cap_x, cap_y, acc_ok, last_step, wd_hit, timeout;
    logic             feed_entry;

    // Accumulator results are only accepted while a step is in flight;
    // stray pulses elsewhere must not disturb the held sums.
    assign cap_x     = xtx_valid && (state == FEED || state == WAIT_ACC);
    assign cap_y     = xty_valid && (state == FEED || state == WAIT_ACC);
    assign acc_ok    = (got_x || cap_x) && (got_y || cap_y);
    assign last_step = (step_idx == last_idx);
    assign wd_hit    = (wd == WDW'(TMO - 1));
    assign mem_addr  = {step_idx, k};

    always_comb begin
        nxt     = state;
        timeout = 1'b0;
        case (state)
            IDLE:     if (start) nxt = FEED;
            FEED:     if (k == K_LAST) nxt = WAIT_ACC;
            WAIT_ACC: begin
                if (acc_ok) nxt = INV;
                else if (wd_hit) begin
                    nxt     = IDLE;
                    timeout = 1'b1;
                end
            end
            INV:      nxt = WAIT_INV;
            WAIT_INV: begin
                if (inv_valid) nxt = STEP_END;
                else if (wd_hit) begin
                    nxt     = IDLE;
                    timeout = 1'b1;
                end
            end
            STEP_END: nxt = last_step ? IDLE : FEED;
            default:  nxt = IDLE;
        endcase
    end

    assign feed_entry = (nxt == FEED) && (state != FEED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd        <= '0;
            k         <= '0;
            step_idx  <= '0;
            last_idx  <= '0;
            got_x     <= 1'b0;
            got_y     <= 1'b0;
            busy      <= 1'b0;
            mem_rd    <= 1'b0;
            acc_start <= 1'b0;
            inv_start <= 1'b0;
            step_done <= 1'b0;
            job_done  <= 1'b0;
            err       <= 1'b0;
            sig0      <= '0;
            sig1      <= '0;
            sig2      <= '0;
            by1       <= '0;
            by2       <= '0;
        end else begin
            // Watchdog restarts on every state change and only runs while waiting.
            if (nxt != state)
                wd <= '0;
            else if (state == WAIT_ACC || state == WAIT_INV)
                wd <= wd + WDW'(1);

            if (feed_entry)
                k <= '0;
            else if (state == FEED && nxt == FEED)
                k <= k + 8'd1;

            if (state == IDLE && start) begin
                step_idx <= '0;
                last_idx <= (n_steps == 8'd0) ? 8'd0 : n_steps - 8'd1;
            end else if (state == STEP_END && !last_step) begin
                step_idx <= step_idx + 8'd1;
            end

            if (feed_entry) begin
                got_x <= 1'b0;
                got_y <= 1'b0;
            end else begin
                if (cap_x) got_x <= 1'b1;
                if (cap_y) got_y <= 1'b1;
            end

            if (cap_x) begin
                sig0 <= ans0;
                sig1 <= ans1;
                sig2 <= ans2;
            end
            if (cap_y) begin
                by1 <= xty1;
                by2 <= xty2;
            end

            busy      <= (nxt != IDLE);
            mem_rd    <= (nxt == FEED);
            acc_start <= feed_entry;
            inv_start <= (nxt == INV) && (state != INV);
            step_done <= (nxt == STEP_END) && (state != STEP_END);
            job_done  <= (nxt == STEP_END) && (state != STEP_END) && last_step;

            if (state == IDLE && start) err <= 1'b0;
            else if (timeout)           err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regr_seq.sv
// tb_regr_seq -- directed bench for regr_seq. Accumulator and MAT_INV
// responses are driven by hand at fixed offsets from the first FEED cycle;
// expected outputs are the hand-chosen constants and cycle positions.
module tb_regr_seq;

    localparam int N_SAMP = 256;
    localparam int TMO    = 1023;

    logic        clk, rst_n, start;
    logic [7:0]  n_steps;
    logic        busy, mem_rd, acc_start, inv_start, inv_valid;
    logic [7:0]  step_idx;
    logic [15:0] mem_addr;
    logic        xtx_valid, xty_valid;
    logic [8:0]  ans0, sig0;
    logic [20:0] ans1, sig1;
    logic [32:0] ans2, sig2, xty1, xty2, by1, by2;
    logic        step_done, job_done, err;

    int checks = 0;
    int errors = 0;

    regr_seq #(.N_SAMP(N_SAMP), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_steps(n_steps),
        .busy(busy), .step_idx(step_idx), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .acc_start(acc_start), .xtx_valid(xtx_valid), .xty_valid(xty_valid),
        .ans0(ans0), .ans1(ans1), .ans2(ans2), .xty1(xty1), .xty2(xty2),
        .sig0(sig0), .sig1(sig1), .sig2(sig2), .inv_start(inv_start),
        .inv_valid(inv_valid), .by1(by1), .by2(by2), .step_done(step_done),
        .job_done(job_done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-step data patterns: distinct per step so a stale capture shows up.
    function automatic logic [8:0]  p_a0(input logic [7:0] s); return 9'h0A5 + 9'(s);                endfunction
    function automatic logic [20:0] p_a1(input logic [7:0] s); return 21'h12345 + 21'(s);            endfunction
    function automatic logic [32:0] p_a2(input logic [7:0] s); return 33'h1_2345_6789 + 33'(s);      endfunction
    function automatic logic [32:0] p_y1(input logic [7:0] s); return 33'h0_DEAD_BEEF + 33'(s);      endfunction
    function automatic logic [32:0] p_y2(input logic [7:0] s); return 33'h1_CAFE_F00D - 33'(s);      endfunction

    task automatic start_job(input logic [7:0] n);
        start   = 1'b1;
        n_steps = n;
        tick();
        start   = 1'b0;
    endtask

    // Entered in the first FEED cycle of step st. dx/dy: cycle offsets from
    // that cycle at which xtx_valid/xty_valid pulse. inv_dly: cycles after
    // inv_start at which inv_valid pulses (<0: never, expect a timeout).
    task automatic run_step(input logic [7:0] st, input int dx, input int dy,
                            input int inv_dly, input logic is_last, input logic poke);
        int lastc;
        chk("acc_start_first", acc_start, 1);
        chk("step_idx", step_idx, st);
        chk("busy_feed", busy, 1);
        for (int k = 0; k < N_SAMP; k++) begin
            chk("mem_addr", mem_addr, {st, 8'(k)});
            chk("mem_rd", mem_rd, 1);
            if (k == 1) chk("acc_start_once", acc_start, 0);
            tick();
        end
        chk("mem_rd_off", mem_rd, 0);
        chk("mem_addr_hold", mem_addr, {st, 8'hFF});
        lastc = (dx > dy) ? dx : dy;
        for (int c = N_SAMP; c <= lastc; c++) begin
            xtx_valid = (c == dx);
            xty_valid = (c == dy);
            ans0 = (c == dx) ? p_a0(st) : ~p_a0(st);
            ans1 = (c == dx) ? p_a1(st) : ~p_a1(st);
            ans2 = (c == dx) ? p_a2(st) : ~p_a2(st);
            xty1 = (c == dy) ? p_y1(st) : ~p_y1(st);
            xty2 = (c == dy) ? p_y2(st) : ~p_y2(st);
            chk("inv_start_early", inv_start, 0);
            tick();
        end
        xtx_valid = 1'b0;
        xty_valid = 1'b0;
        ans0 = '0; ans1 = '0; ans2 = '0; xty1 = '0; xty2 = '0;
        chk("inv_start", inv_start, 1);
        chk("sig0", sig0, p_a0(st));
        chk("sig1", sig1, p_a1(st));
        chk("sig2", sig2, p_a2(st));
        chk("by1", by1, p_y1(st));
        chk("by2", by2, p_y2(st));
        if (inv_dly >= 0) begin
            for (int c = 1; c <= inv_dly; c++) begin
                tick();
                chk("inv_start_once", inv_start, 0);
                chk("sig0_stable", sig0, p_a0(st));
                if (poke && c == 2) begin
                    start   = 1'b1;
                    n_steps = 8'd1;
                end else begin
                    start = 1'b0;
                end
                if (c == inv_dly) inv_valid = 1'b1;
            end
            tick();
            inv_valid = 1'b0;
            chk("step_done", step_done, 1);
            chk("job_done", job_done, is_last);
            chk("step_idx_end", step_idx, st);
            tick();
            chk("step_done_pulse", step_done, 0);
            chk("job_done_pulse", job_done, 0);
            if (is_last) chk("busy_after_job", busy, 0);
        end else begin
            for (int c = 1; c <= TMO; c++) begin
                tick();
                if (c == 1 || c == TMO) begin
                    chk("err_before_tmo", err, 0);
                    chk("busy_before_tmo", busy, 1);
                end
            end
            tick();
            chk("err_tmo", err, 1);
            chk("busy_tmo", busy, 0);
            chk("step_done_tmo", step_done, 0);
            chk("job_done_tmo", job_done, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; n_steps = 8'd0;
        xtx_valid = 1'b0; xty_valid = 1'b0; inv_valid = 1'b0;
        ans0 = '0; ans1 = '0; ans2 = '0; xty1 = '0; xty2 = '0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_step_idx", step_idx, 0);
        chk("rst_err", err, 0);
        chk("rst_sig2", sig2, 0);
        chk("rst_by1", by1, 0);
        rst_n = 1'b1;

        // Single step, both valids at S+258, inverse 6 cycles after inv_start.
        start_job(8'd1);
        run_step(8'd0, 258, 258, 6, 1'b1, 1'b0);

        // Valid pulses in IDLE must not touch the held sums.
        xtx_valid = 1'b1; xty_valid = 1'b1;
        ans0 = 9'h1FF; xty1 = 33'h1_FFFF_FFFF;
        tick();
        xtx_valid = 1'b0; xty_valid = 1'b0;
        tick();
        chk("idle_sig0", sig0, p_a0(8'd0));
        chk("idle_by1", by1, p_y1(8'd0));
        chk("idle_busy", busy, 0);

        // Three steps; start + n_steps change during WAIT_INV of step 0 ignored.
        // Step 1 has xty 5 cycles ahead of xtx; step 2 the reverse order.
        start_job(8'd3);
        run_step(8'd0, 258, 258, 6, 1'b0, 1'b1);
        run_step(8'd1, 263, 258, 6, 1'b0, 1'b0);
        run_step(8'd2, 257, 260, 3, 1'b1, 1'b0);

        // Watchdog: MAT_INV never answers.
        start_job(8'd1);
        run_step(8'd0, 256, 256, -1, 1'b1, 1'b0);
        tick();
        chk("err_sticky", err, 1);
        start_job(8'd2);
        chk("err_cleared", err, 0);
        chk("busy_restart", busy, 1);

        // Reset at k=100 of the step-0 burst.
        for (int k = 0; k < 100; k++) tick();
        chk("mem_addr_k100", mem_addr, 16'h0064);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_rd", mem_rd, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_addr", mem_addr, 0);
        chk("rst_mid_sig0", sig0, 0);
        rst_n = 1'b1;

        // n_steps = 0 behaves as a single step.
        start_job(8'd0);
        run_step(8'd0, 258, 258, 6, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regr_seq.md
REGR_SEQ -- requirements
Module: regr_seq

Interface
REQ-001 Parameter N_SAMP, default 256, samples per regression; equals XTX/XTY accumulation length.
REQ-002 Parameter TMO, default 1023, watchdog limit in cycles for any wait state.
REQ-003 clk  in  1  clock; all logic rising-edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  host request; sampled only in IDLE.
REQ-006 n_steps  in  8  regressions per job; 0 treated as 1; sampled with start.
REQ-007 busy  out  1  high in every state except IDLE.
REQ-008 step_idx  out  8  index of current regression, 0..n_steps-1.
REQ-009 mem_rd  out  1  sample-memory read enable; memory has 1-cycle read latency.
REQ-010 mem_addr  out  16  {step_idx, k}, k = sample index 0..N_SAMP-1.
REQ-011 acc_start  out  1  one-cycle start pulse, shared by XTX and XTY.
REQ-012 xtx_valid, xty_valid  in  1 each  one-cycle completion pulses.
REQ-013 ans0/ans1/ans2  in  9/21/33  XTX sums, valid with xtx_valid.
REQ-014 xty1/xty2  in  33/33  XTY sums, valid with xty_valid.
REQ-015 sig0/sig1/sig2  out  9/21/33  held XTX sums driving MAT_INV.
REQ-016 inv_start  out  1  one-cycle MAT_INV start pulse.
REQ-017 inv_valid  in  1  MAT_INV completion pulse.
REQ-018 by1/by2  out  33/33  held XTY sums for the current step.
REQ-019 step_done  out  1  one-cycle pulse at end of each regression.
REQ-020 job_done  out  1  one-cycle pulse coinciding with step_done of the last step.
REQ-021 err  out  1  sticky watchdog flag; cleared by the next accepted start.

Function
REQ-022 States: IDLE, FEED, WAIT_ACC, INV, WAIT_INV, STEP_END; all outputs registered.
REQ-023 IDLE: start=1 at cycle C -> FEED at C+1; latch n_steps; step_idx=0; err=0; start while busy ignored.
REQ-024 FEED, first cycle S: acc_start=1 for exactly that cycle; mem_rd=1 and mem_addr k = cycle S+k, k=0..N_SAMP-1, so data k reaches XTX/XTY in cycle S+1+k.
REQ-025 After k=N_SAMP-1: mem_rd=0 -> WAIT_ACC; mem_addr holds last value.
REQ-026 xtx_valid and xty_valid captured independently into got_x/got_y flags in any state from FEED to WAIT_ACC, in either order or the same cycle; xtx_valid loads sig0..2 from ans0..2, xty_valid loads by1..2 from xty1..2.
REQ-027 WAIT_ACC: when got_x and got_y are both set (including the capture cycle) -> INV next cycle.
REQ-028 INV: inv_start=1 for one cycle -> WAIT_INV; sig0..2 stay stable until inv_valid.
REQ-029 WAIT_INV: inv_valid=1 -> STEP_END.
REQ-030 STEP_END (one cycle): step_done=1; job_done=1 if step_idx=n_steps-1, then -> IDLE; else step_idx+1, clear got_x/got_y, -> FEED.
REQ-031 Watchdog counter clears on every state entry and counts in WAIT_ACC and WAIT_INV; reaching TMO -> err=1, IDLE next cycle, no step_done or job_done.
REQ-032 Valid pulses arriving in IDLE or STEP_END are ignored; sig/by retain values.
REQ-033 Data is transferred without modification; no arithmetic other than the counters.

Reset
REQ-034 rst_n low, any state or mid-FEED: IDLE, all pulses/busy/mem_rd/err=0, step_idx=0, mem_addr=0, sig*/by*=0, flags and watchdog cleared.
REQ-035 Release: first start accepted on the first rising edge with rst_n high.

Verification
REQ-036 Single step: n_steps=1, start 1 cycle, models with XTX/XTY valid at S+258, MAT_INV valid 6 cycles after inv_start -> acc_start once, mem_addr 0x0000..0x00FF contiguous, inv_start 1 cycle after capture, step_done and job_done in the same cycle.
REQ-037 Multi-step: n_steps=3 -> 3 FEED bursts with mem_addr high byte 0,1,2; 3 step_done pulses; job_done only with the third.
REQ-038 Skewed valids: xty_valid 5 cycles before xtx_valid -> inv_start only after xtx_valid; by1/by2 equal the xty values at their valid pulse.
REQ-039 Timeout: inv_valid never asserted -> err=1 TMO cycles after WAIT_INV entry, then IDLE, busy=0; next start clears err.
REQ-040 Reset during FEED at k=100 -> mem_rd=0 and busy=0 immediately; a fresh start restarts at mem_addr 0x0000.
REQ-041 start pulsed during WAIT_INV -> no effect; n_steps change while busy -> not applied.
